// File: rtl/hs_upload_server.sv
// hs_upload_server: serves the HPS ioctl upload stream (core -> HPS) for hiscore/NVRAM saving.
// Requests an autosave when the OSD opens with dirty RAM, pauses the game CPU for the duration
// of an upload session, and reads the tracked RAM window byte-by-byte onto ioctl_din while
// stalling the HPS with ioctl_wait.
module hs_upload_server #(
    parameter int unsigned       ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter int unsigned       SIZE    = 256,
    parameter int unsigned       RAM_LAT = 2,
    parameter logic [7:0]        IDX     = 8'd4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    input  logic              autosave,
    input  logic              osd_open,
    input  logic              ram_dirty,
    output logic              pause_req,
    input  logic              paused,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAUSE,
        S_READY,
        S_FETCH
    } state_t;

    state_t              r_state;
    logic                r_pend;
    logic [24:0]         r_pend_addr;
    logic [2:0]          r_cnt;
    logic [7:0]          r_din;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_rd;
    logic                r_pause_req;
    logic                r_upload_req;
    logic                r_dirty;
    logic                r_osd_d;
    logic                r_sess_d;

    logic                w_session;
    logic                w_sess_start;
    logic [24:0]         w_req_addr;
    logic                w_oob;
    state_t              w_state_nxt;
    logic                w_pend_nxt;
    logic [24:0]         w_pend_addr_nxt;
    logic [2:0]          w_cnt_nxt;
    logic [7:0]          w_din_nxt;
    logic [ADDR_W-1:0]   w_ram_addr_nxt;
    logic                w_ram_rd_nxt;

    assign w_session    = ioctl_upload && (ioctl_index == IDX);
    assign w_sess_start = (r_state == S_IDLE) && w_session && !r_sess_d;

    // A fresh strobe takes precedence over an address parked while the CPU was not yet paused.
    assign w_req_addr   = ioctl_rd ? ioctl_addr : r_pend_addr;
    // Compare the full 25-bit offset so high offsets never alias back into the window.
    assign w_oob        = ({1'b0, w_req_addr} >= 26'(SIZE));

    // Next-state and datapath updates; a falling session overrides everything else.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = r_pend;
        w_pend_addr_nxt = r_pend_addr;
        w_cnt_nxt       = r_cnt;
        w_din_nxt       = r_din;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_rd_nxt    = 1'b0;

        if ((r_state != S_IDLE) && !w_session) begin
            w_state_nxt = S_IDLE;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sess_start) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (ioctl_rd) begin
                        w_pend_nxt      = 1'b1;
                        w_pend_addr_nxt = ioctl_addr;
                    end
                    if (paused) begin
                        w_state_nxt = S_READY;
                    end
                end
                S_READY: begin
                    if (!paused) begin
                        // CPU resumed under us: hold any new request until pause is re-acknowledged.
                        w_state_nxt = S_PAUSE;
                        if (ioctl_rd) begin
                            w_pend_nxt      = 1'b1;
                            w_pend_addr_nxt = ioctl_addr;
                        end
                    end else if (ioctl_rd || r_pend) begin
                        w_pend_nxt = 1'b0;
                        if (w_oob) begin
                            w_din_nxt = 8'hFF;
                        end else begin
                            w_ram_addr_nxt = BASE + w_req_addr[ADDR_W-1:0];
                            w_ram_rd_nxt   = 1'b1;
                            w_cnt_nxt      = 3'd0;
                            w_state_nxt    = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // ram_rd was on the bus the cycle after entry, so data lands RAM_LAT edges later.
                    if (r_cnt == 3'(RAM_LAT)) begin
                        w_din_nxt   = ram_data;
                        w_state_nxt = S_READY;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register and control/output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pend       <= 1'b0;
            r_cnt        <= 3'd0;
            r_din        <= 8'h00;
            r_ram_addr   <= '0;
            r_ram_rd     <= 1'b0;
            r_pause_req  <= 1'b0;
            r_sess_d     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend       <= w_pend_nxt;
            r_cnt        <= w_cnt_nxt;
            r_din        <= w_din_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_rd     <= w_ram_rd_nxt;
            r_pause_req  <= (w_state_nxt != S_IDLE);
            r_sess_d     <= w_session;
        end
    end

    // Parked request offset; only meaningful while r_pend is set, so it needs no reset.
    always_ff @(posedge clk_sys) begin
        r_pend_addr <= w_pend_addr_nxt;
    end

    // Dirty tracking and autosave request on the OSD-open rising edge; a new write beats the clear.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dirty      <= 1'b0;
            r_osd_d      <= 1'b0;
            r_upload_req <= 1'b0;
        end else begin
            if (ram_dirty) begin
                r_dirty <= 1'b1;
            end else if (w_sess_start) begin
                r_dirty <= 1'b0;
            end
            r_osd_d      <= osd_open;
            r_upload_req <= osd_open && !r_osd_d && autosave && r_dirty && (r_state == S_IDLE);
        end
    end

    // HPS must not strobe again while a fetch is in flight; such a strobe is dropped.
    a_no_rd_in_fetch: assert property (@(posedge clk_sys) disable iff (reset)
        !(w_session && (r_state == S_FETCH) && ioctl_rd));

    assign ioctl_din        = r_din;
    assign ioctl_wait       = w_session && (ioctl_rd || r_pend || (r_state == S_FETCH) ||
                                            ((r_state == S_PAUSE) && ioctl_rd));
    assign ioctl_upload_req = r_upload_req;
    assign pause_req        = r_pause_req;
    assign ram_rd           = r_ram_rd;
    assign ram_addr         = r_ram_addr;
    assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_hs_upload_server.sv
// Testbench for hs_upload_server: directed session scenarios plus randomized reads checked
// against a byte-level model of the upload window (offset -> RAM byte or 8'hFF).
module tb_hs_upload_server;

    localparam int          ADDR_W  = 16;
    localparam logic [15:0] BASE    = 16'hFFF0;
    localparam int          SIZE    = 256;
    localparam int          RAM_LAT = 2;
    localparam logic [7:0]  IDX     = 8'd4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;
    logic        autosave;
    logic        osd_open;
    logic        ram_dirty;
    logic        pause_req;
    logic        paused;
    logic        ram_rd;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        busy;

    always #5 clk_sys = ~clk_sys;

    hs_upload_server #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .SIZE   (SIZE),
        .RAM_LAT(RAM_LAT),
        .IDX    (IDX)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ioctl_upload    (ioctl_upload),
        .ioctl_index     (ioctl_index),
        .ioctl_rd        (ioctl_rd),
        .ioctl_addr      (ioctl_addr),
        .ioctl_din       (ioctl_din),
        .ioctl_wait      (ioctl_wait),
        .ioctl_upload_req(ioctl_upload_req),
        .autosave        (autosave),
        .osd_open        (osd_open),
        .ram_dirty       (ram_dirty),
        .pause_req       (pause_req),
        .paused          (paused),
        .ram_rd          (ram_rd),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .busy            (busy)
    );

    // Game RAM with RAM_LAT cycles of read latency.
    logic [7:0] mem [0:65535];
    logic [7:0] rpipe [RAM_LAT];
    always @(posedge clk_sys) begin
        rpipe[0] <= mem[ram_addr];
        for (int i = 1; i < RAM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_data = rpipe[RAM_LAT-1];

    // Bus monitor: counts RAM strobes and upload requests.
    int          rd_cnt  = 0;
    int          req_cnt = 0;
    logic [15:0] last_ram_addr = 16'h0;
    always @(negedge clk_sys) begin
        if (ram_rd === 1'b1) begin
            rd_cnt++;
            last_ram_addr = ram_addr;
        end
        if (ioctl_upload_req === 1'b1) req_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference: byte the HPS should receive for a given upload offset.
    function automatic logic [7:0] model_byte(input logic [24:0] a);
        logic [15:0] ra;
        if (a >= 25'(SIZE)) return 8'hFF;
        ra = BASE + a[15:0];
        return mem[ra];
    endfunction

    // One read with the CPU already paused; checks data, latency, RAM strobe count and address.
    task automatic do_read(input string tag, input logic [24:0] a);
        int         base_cnt;
        int         lat;
        logic [7:0] e;
        bit         oob;
        oob      = (a >= 25'(SIZE));
        e        = model_byte(a);
        base_cnt = rd_cnt;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        #1;
        chk({tag, "_wait_on_rd"}, ioctl_wait, 1);
        tick();
        ioctl_rd = 1'b0;
        #1;
        lat = 0;
        while (ioctl_wait && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, oob ? 0 : RAM_LAT + 1);
        chk({tag, "_din"}, ioctl_din, e);
        chk({tag, "_ram_rd_cnt"}, rd_cnt - base_cnt, oob ? 0 : 1);
        if (!oob) chk({tag, "_ram_addr"}, last_ram_addr, 16'(BASE + a[15:0]));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          c0;
        int          hi;
        int          lat;
        logic [24:0] a;
        logic [7:0]  d0;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'(BASE + 16'd5)] = 8'hA7;

        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
        ioctl_addr = '0; autosave = 1'b0; osd_open = 1'b0; ram_dirty = 1'b0; paused = 1'b0;
        repeat (3) tick();

        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_ram_addr", ram_addr, 16'h0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_upload_req", ioctl_upload_req, 0);
        chk("rst_pause_req", pause_req, 0);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Autosave request: one pulse with autosave, none without.
        ram_dirty = 1'b1; tick(); ram_dirty = 1'b0;
        autosave = 1'b1; tick();
        c0 = req_cnt; osd_open = 1'b1; repeat (4) tick();
        chk("req_autosave_on", req_cnt - c0, 1);
        osd_open = 1'b0; tick();
        autosave = 1'b0;
        c0 = req_cnt; osd_open = 1'b1; repeat (4) tick();
        chk("req_autosave_off", req_cnt - c0, 0);
        osd_open = 1'b0; autosave = 1'b1; tick();

        // Foreign index: block stays idle and leaves the bus alone.
        ioctl_index = 8'd3; ioctl_upload = 1'b1; paused = 1'b1;
        repeat (3) tick();
        chk("other_busy", busy, 0);
        chk("other_pause_req", pause_req, 0);
        c0 = rd_cnt;
        ioctl_addr = 25'd5; ioctl_rd = 1'b1; #1;
        chk("other_wait", ioctl_wait, 0);
        tick(); ioctl_rd = 1'b0;
        repeat (RAM_LAT + 2) tick();
        chk("other_din", ioctl_din, 8'h00);
        chk("other_ram_rd", rd_cnt - c0, 0);
        ioctl_upload = 1'b0; paused = 1'b0; tick();

        // Session start clears dirty.
        ioctl_index = IDX; ioctl_upload = 1'b1; tick();
        chk("start_pause_req", pause_req, 1);
        chk("start_busy", busy, 1);
        tick(); ioctl_upload = 1'b0; tick();
        chk("end_pause_req", pause_req, 0);
        c0 = req_cnt; osd_open = 1'b1; repeat (3) tick(); osd_open = 1'b0;
        chk("req_after_clear", req_cnt - c0, 0);
        tick();

        // Session with a dirty pulse on the start cycle; CPU acknowledges after 3 clk.
        ioctl_upload = 1'b1; ram_dirty = 1'b1; tick(); ram_dirty = 1'b0;
        tick(); tick();
        chk("pause_wait_idle", ioctl_wait, 0);
        paused = 1'b1; tick(); tick();
        do_read("rd5", 25'd5);
        chk("rd5_value", ioctl_din, 8'hA7);
        do_read("rd_size", 25'(SIZE));
        chk("rd_size_value", ioctl_din, 8'hFF);
        do_read("rd_last", 25'(SIZE - 1));

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: a = 25'($urandom_range(0, SIZE - 1));
                1: a = ($urandom_range(0, 1) != 0) ? 25'd0 : 25'(SIZE - 1);
                2: a = 25'($urandom);
                default: a = 25'(SIZE + $urandom_range(0, 15));
            endcase
            do_read("rand", a);
        end

        // CPU resumes; a read arriving then must wait for re-acknowledge.
        paused = 1'b0; tick();
        c0 = rd_cnt;
        ioctl_addr = 25'd7; ioctl_rd = 1'b1; tick();
        ioctl_rd = 1'b0; ioctl_addr = 25'd0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (ioctl_wait === 1'b1) hi++;
            tick();
        end
        chk("unpaused_wait_held", hi, 10);
        chk("unpaused_no_ram_rd", rd_cnt - c0, 0);
        paused = 1'b1; #1;
        lat = 0;
        while (ioctl_wait && lat < 40) begin
            tick();
            lat++;
        end
        chk("unpaused_done", ioctl_wait, 0);
        chk("unpaused_din", ioctl_din, model_byte(25'd7));
        chk("unpaused_ram_rd", rd_cnt - c0, 1);
        chk("unpaused_ram_addr", last_ram_addr, 16'(BASE + 16'd7));

        // Session drops mid-fetch: in-flight byte is discarded.
        d0 = model_byte(25'd7);
        mem[16'(BASE + 16'd9)] = ~d0;
        ioctl_addr = 25'd9; ioctl_rd = 1'b1; tick();
        ioctl_rd = 1'b0; tick();
        chk("drop_in_fetch_wait", ioctl_wait, 1);
        ioctl_upload = 1'b0; tick();
        chk("drop_busy", busy, 0);
        chk("drop_pause_req", pause_req, 0);
        chk("drop_din", ioctl_din, d0);
        repeat (4) tick();
        chk("drop_din_hold", ioctl_din, d0);

        // Dirty set on the start cycle survived the session.
        c0 = req_cnt; osd_open = 1'b1; repeat (3) tick(); osd_open = 1'b0;
        chk("req_dirty_set_wins", req_cnt - c0, 1);
        tick();

        // Reset in the middle of a fetch.
        ioctl_upload = 1'b1; tick(); tick(); tick();
        ioctl_addr = 25'd3; ioctl_rd = 1'b1; tick();
        ioctl_rd = 1'b0; tick();
        chk("rfetch_wait", ioctl_wait, 1);
        reset = 1'b1; tick();
        chk("rfetch_din", ioctl_din, 8'h00);
        chk("rfetch_ram_addr", ram_addr, 16'h0);
        chk("rfetch_wait_low", ioctl_wait, 0);
        chk("rfetch_pause_req", pause_req, 0);
        chk("rfetch_busy", busy, 0);
        chk("rfetch_ram_rd", ram_rd, 0);
        chk("rfetch_upload_req", ioctl_upload_req, 0);
        ioctl_upload = 1'b0; tick();
        reset = 1'b0; tick();
        chk("post_reset_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
